// File: rtl/random_tile_field_if.sv
// Bus bundle between the frame/level controller (master) and the tile field (slave).
interface random_tile_field_if #(
  parameter int NUM_TILES = 4
) ();
  logic                     startOfFrame;
  logic                     startOfLevel;
  logic                     endLevel;
  logic                     oneTensSec;
  logic [31:0]              levelSpeed;
  logic [10:0]              pixelX;
  logic [10:0]              pixelY;
  logic [NUM_TILES-1:0]     drawingRequestVector;
  logic [8*NUM_TILES-1:0]   RGBoutVector;
  logic                     drawingRequest;
  logic [7:0]               RGBout;
  logic [2:0]               hitIndex;

  modport master (
    output startOfFrame, startOfLevel, endLevel, oneTensSec, levelSpeed, pixelX, pixelY,
    input  drawingRequestVector, RGBoutVector, drawingRequest, RGBout, hitIndex
  );

  modport slave (
    input  startOfFrame, startOfLevel, endLevel, oneTensSec, levelSpeed, pixelX, pixelY,
    output drawingRequestVector, RGBoutVector, drawingRequest, RGBout, hitIndex
  );
endinterface

// File: rtl/random_tile_field.sv
// NUM_TILES scrolling obstacle tiles. Each channel waits a staggered number of
// 100 ms ticks, spawns at the right screen edge at an LFSR-chosen Y, scrolls left
// by levelSpeed per frame and re-arms after leaving the screen. Drawing outputs
// are registered one clock after the pixel coordinates; lowest index wins.
module random_tile_field #(
  parameter int          NUM_TILES     = 4,
  parameter int          TILE_W        = 32,
  parameter int          TILE_H        = 32,
  parameter int          SCREEN_W      = 640,
  parameter int          Y_MIN         = 32,
  parameter int          Y_MAX         = 416,
  parameter int          RESPAWN_TICKS = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [7:0]  TILE_RGB      = 8'h1C,
  parameter logic [7:0]  BORDER_RGB    = 8'h00
) (
  input  logic                clk,
  input  logic                resetN,
  random_tile_field_if.slave  bus
);

  localparam int                Y_RANGE    = Y_MAX - Y_MIN;
  localparam int                CNT_W      = $clog2(RESPAWN_TICKS * NUM_TILES + 1);
  localparam logic signed [12:0] NEG_TILE_W = 13'(-TILE_W);
  localparam logic signed [12:0] TW13       = 13'(TILE_W);
  localparam logic signed [12:0] TH13       = 13'(TILE_H);
  localparam logic [11:0]        SPAWN_X    = 12'(SCREEN_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } tile_state_t;

  // Galois step, taps 16'hB400.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Low 9 bits of the LFSR rotated left by sh (sh taken modulo 16).
  function automatic logic [8:0] lfsr_pick(input logic [15:0] v, input int sh);
    logic [31:0] w_dbl;
    w_dbl = {v, v} << (sh % 16);
    return w_dbl[24:16];
  endfunction

  // Fold a 9-bit random value into [Y_MIN, Y_MAX].
  function automatic logic [11:0] spawn_y(input logic [8:0] r);
    logic [8:0] w_off;
    if (r <= 9'(Y_RANGE)) begin
      w_off = r;
    end else begin
      w_off = r - 9'(Y_RANGE + 1);
    end
    return 12'(Y_MIN) + {3'b000, w_off};
  endfunction

  logic [15:0]              r_lfsr;
  logic [NUM_TILES-1:0]     w_hit;
  logic [8*NUM_TILES-1:0]   w_lane_rgb;
  logic [7:0]               w_sel_rgb;
  logic [2:0]               w_sel_idx;
  logic signed [12:0]       w_px;
  logic signed [12:0]       w_py;
  logic                     w_unused_speed_hi;

  logic [NUM_TILES-1:0]     r_drv;
  logic [8*NUM_TILES-1:0]   r_rgbv;
  logic                     r_dr;
  logic [7:0]               r_rgb;
  logic [2:0]               r_idx;

  assign w_px              = $signed({2'b00, bus.pixelX});
  assign w_py              = $signed({2'b00, bus.pixelY});
  assign w_unused_speed_hi = |bus.levelSpeed[31:8];

  // Free-running random source shared by all channels.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_tile
    tile_state_t        r_state;
    logic signed [11:0] r_x;
    logic signed [11:0] r_y;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_stagger;
    logic signed [12:0] w_x;
    logic signed [12:0] w_y;
    logic signed [12:0] w_next_x;
    logic               w_in_x;
    logic               w_in_y;
    logic               w_edge;

    assign w_stagger = CNT_W'(RESPAWN_TICKS * (g + 1));
    assign w_x       = {r_x[11], r_x};
    assign w_y       = {r_y[11], r_y};
    assign w_next_x  = w_x - $signed({5'b00000, bus.levelSpeed[7:0]});

    // Spawn / scroll / respawn sequencing for this channel.
    always_ff @(posedge clk) begin
      if (!resetN) begin
        r_state <= ST_IDLE;
        r_x     <= 12'sd0;
        r_y     <= 12'sd0;
        r_cnt   <= '0;
      end else if (bus.endLevel) begin
        r_state <= ST_IDLE;
        r_x     <= 12'sd0;
        r_y     <= 12'sd0;
        r_cnt   <= '0;
      end else if (bus.startOfLevel) begin
        r_state <= ST_WAIT;
        r_x     <= 12'sd0;
        r_y     <= 12'sd0;
        r_cnt   <= w_stagger;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_WAIT: begin
            if (bus.oneTensSec) begin
              r_cnt <= r_cnt - CNT_W'(1);
              if (r_cnt == CNT_W'(1)) begin
                r_state <= ST_ACTIVE;
                r_x     <= SPAWN_X;
                r_y     <= spawn_y(lfsr_pick(r_lfsr, 3 * g));
              end
            end
          end
          ST_ACTIVE: begin
            if (bus.startOfFrame) begin
              r_x <= w_next_x[11:0];
              if (w_next_x <= NEG_TILE_W) begin
                r_state <= ST_WAIT;
                r_cnt   <= CNT_W'(RESPAWN_TICKS);
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_x     <= 12'sd0;
            r_y     <= 12'sd0;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_in_x = (w_px >= w_x) && (w_px < w_x + TW13);
    assign w_in_y = (w_py >= w_y) && (w_py < w_y + TH13);
    assign w_hit[g] = (r_state == ST_ACTIVE) && w_in_x && w_in_y;
    assign w_edge = (w_px == w_x) || (w_px == w_x + TW13 - 13'sd1) ||
                    (w_py == w_y) || (w_py == w_y + TH13 - 13'sd1);
    assign w_lane_rgb[g*8 +: 8] = w_hit[g] ? (w_edge ? BORDER_RGB : TILE_RGB) : 8'hFF;
  end

  // Lowest-index hit wins; scan from the top so the lowest index is applied last.
  always_comb begin
    w_sel_rgb = 8'hFF;
    w_sel_idx = 3'd0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel_rgb = w_lane_rgb[i*8 +: 8];
        w_sel_idx = 3'(i);
      end else begin
        w_sel_rgb = w_sel_rgb;
        w_sel_idx = w_sel_idx;
      end
    end
  end

  // Register all drawing outputs (one clock after the pixel coordinates).
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_drv  <= '0;
      r_rgbv <= '1;
      r_dr   <= 1'b0;
      r_rgb  <= 8'hFF;
      r_idx  <= 3'd0;
    end else begin
      r_drv  <= w_hit;
      r_rgbv <= w_lane_rgb;
      r_dr   <= |w_hit;
      r_rgb  <= w_sel_rgb;
      r_idx  <= w_sel_idx;
    end
  end

  assign bus.drawingRequestVector = r_drv;
  assign bus.RGBoutVector         = r_rgbv;
  assign bus.drawingRequest       = r_dr;
  assign bus.RGBout               = r_rgb;
  assign bus.hitIndex             = r_idx;

endmodule

// File: tb/tb_random_tile_field.sv
// Randomized bench for random_tile_field against a per-tile behavioural model
// (integer positions, tick counters and an integer LFSR), plus directed
// scenarios for spawning, scrolling off, pixel scanning, overlap and reset.
module tb_random_tile_field;
  localparam int NT   = 4;
  localparam int TW   = 32;
  localparam int TH   = 32;
  localparam int SW   = 640;
  localparam int YMIN = 32;
  localparam int YMAX = 416;
  localparam int RT   = 10;
  localparam int SEED = 16'hACE1;
  localparam logic [7:0] TRGB = 8'h1C;
  localparam logic [7:0] BRGB = 8'h00;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  random_tile_field_if #(.NUM_TILES(NT)) bus ();
  random_tile_field #(.NUM_TILES(NT)) dut (.clk(clk), .resetN(resetN), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_st [NT];   // 0 idle, 1 waiting, 2 on screen
  int m_x  [NT];
  int m_y  [NT];
  int m_cnt[NT];
  int m_lfsr;
  bit m_valid = 1'b0;
  logic [NT-1:0]   e_drv;
  logic [8*NT-1:0] e_rgbv;
  logic            e_dr;
  logic [7:0]      e_rgb;
  logic [2:0]      e_idx;

  function automatic int lfsr_after(input int v);
    int n;
    n = v >> 1;
    if ((v & 1) != 0) n = n ^ 'hB400;
    return n;
  endfunction

  function automatic int pick_r(input int v, input int i);
    int k;
    int rot;
    k = (3 * i) % 16;
    rot = ((v << k) | (v >> (16 - k))) & 'hFFFF;
    return rot & 511;
  endfunction

  function automatic int pick_y(input int v, input int i);
    int r;
    r = pick_r(v, i);
    if (r > YMAX - YMIN) r = r - (YMAX - YMIN + 1);
    return YMIN + r;
  endfunction

  always @(posedge clk) begin
    if (!resetN) begin
      m_valid = 1'b1;
      for (int i = 0; i < NT; i++) begin
        m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_cnt[i] = 0;
      end
      m_lfsr = SEED;
      e_drv = '0; e_rgbv = '1; e_dr = 1'b0; e_rgb = 8'hFF; e_idx = 3'd0;
    end else if (m_valid) begin
      int px, py, spd;
      bit found, hit, edge_px;
      logic [7:0] lane;
      px = int'(bus.pixelX);
      py = int'(bus.pixelY);
      spd = int'(bus.levelSpeed & 32'h0000_00FF);
      found = 1'b0;
      e_rgb = 8'hFF; e_idx = 3'd0;
      for (int i = 0; i < NT; i++) begin
        hit = (m_st[i] == 2) && px >= m_x[i] && px < m_x[i] + TW && py >= m_y[i] && py < m_y[i] + TH;
        edge_px = px == m_x[i] || px == m_x[i] + TW - 1 || py == m_y[i] || py == m_y[i] + TH - 1;
        lane = hit ? (edge_px ? BRGB : TRGB) : 8'hFF;
        e_drv[i] = hit;
        e_rgbv[i*8 +: 8] = lane;
        if (hit && !found) begin
          found = 1'b1; e_rgb = lane; e_idx = 3'(i);
        end
      end
      e_dr = found;
      for (int i = 0; i < NT; i++) begin
        if (bus.endLevel) begin
          m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_cnt[i] = 0;
        end else if (bus.startOfLevel) begin
          m_st[i] = 1; m_cnt[i] = RT * (i + 1); m_x[i] = 0; m_y[i] = 0;
        end else if (m_st[i] == 1 && bus.oneTensSec) begin
          if (m_cnt[i] == 1) begin
            m_st[i] = 2; m_x[i] = SW; m_y[i] = pick_y(m_lfsr, i);
          end
          m_cnt[i] = m_cnt[i] - 1;
        end else if (m_st[i] == 2 && bus.startOfFrame) begin
          m_x[i] = m_x[i] - spd;
          if (m_x[i] <= -TW) begin
            m_st[i] = 1; m_cnt[i] = RT;
          end
        end
      end
      m_lfsr = lfsr_after(m_lfsr);
    end
  end

  // Compare every registered output on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check_eq("drawingRequestVector", 64'(bus.drawingRequestVector), 64'(e_drv));
      check_eq("RGBoutVector", 64'(bus.RGBoutVector), 64'(e_rgbv));
      check_eq("drawingRequest", 64'(bus.drawingRequest), 64'(e_dr));
      check_eq("RGBout", 64'(bus.RGBout), 64'(e_rgb));
      check_eq("hitIndex", 64'(bus.hitIndex), 64'(e_idx));
    end
  end

  // ---------------- stimulus ----------------
  int spd = 0;

  task automatic step_px(input bit sof, input bit sol, input bit endl, input bit tick,
                         input bit rst, input int px, input int py);
    bus.startOfFrame = sof;
    bus.startOfLevel = sol;
    bus.endLevel     = endl;
    bus.oneTensSec   = tick;
    resetN           = !rst;
    bus.levelSpeed   = ($urandom() & 32'hFFFF_FF00) | 32'(spd & 255);
    bus.pixelX       = 11'(px);
    bus.pixelY       = 11'(py);
    @(negedge clk);
  endtask

  // Pixels mostly land around an on-screen tile so edges and interiors are probed.
  task automatic step(input bit sof, input bit sol, input bit endl, input bit tick, input bit rst);
    int px, py, t, na;
    int act[NT];
    na = 0;
    for (int i = 0; i < NT; i++) if (m_st[i] == 2) begin act[na] = i; na++; end
    if (na > 0 && $urandom_range(0, 3) != 0) begin
      t = act[$urandom_range(0, na - 1)];
      px = m_x[t] + $urandom_range(0, TW + 3) - 2;
      py = m_y[t] + $urandom_range(0, TH + 3) - 2;
      if (px < 0) px = $urandom_range(0, 40);
    end else if ($urandom_range(0, 9) == 0) begin
      px = $urandom_range(0, 2047); py = $urandom_range(0, 2047);
    end else begin
      px = $urandom_range(0, 700); py = $urandom_range(0, 480);
    end
    step_px(sof, sol, endl, tick, rst, px, py);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0); end
  endtask

  task automatic frames(input int n);
    repeat (n) begin step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); end
  endtask

  // Idle until channel 0 would draw the wanted random value on the next tick.
  task automatic wait_r0(input int target);
    int n;
    n = 0;
    while (pick_r(m_lfsr, 0) != target && n < 8000) begin
      step(0, 0, 0, 0, 0); n++;
    end
    check_eq("search_r0", 64'(pick_r(m_lfsr, 0)), 64'(target));
  endtask

  initial begin
    int x0, y0, d, n, yy;
    int dys[6];
    dys = '{-1, 0, 1, 16, 31, 32};
    repeat (3) step(0, 0, 0, 0, 1);

    // Spawn channel 0 with r=400 (folds to y=47), probe edges.
    step(0, 1, 0, 0, 0);
    ticks(9);
    wait_r0(400);
    step(0, 0, 0, 1, 0);
    step_px(0, 0, 0, 0, 0, 640, 47);
    step_px(0, 0, 0, 0, 0, 640, 46);
    step_px(0, 0, 0, 0, 0, 671, 78);
    step_px(0, 0, 0, 0, 0, 650, 79);
    step_px(0, 0, 0, 0, 0, 655, 60);

    // Restart and spawn with r=0 (y=32).
    step(0, 1, 0, 0, 0);
    ticks(9);
    wait_r0(0);
    step(0, 0, 0, 1, 0);
    step_px(0, 0, 0, 0, 0, 640, 32);
    step_px(0, 0, 0, 0, 0, 641, 33);
    step_px(0, 0, 0, 0, 0, 641, 31);

    // Staggered spawn, scroll at 8 px/frame, scan, then scroll off.
    step(0, 1, 0, 0, 0);
    ticks(10);
    spd = 8;
    frames(67);
    x0 = m_x[0]; y0 = m_y[0];
    for (int k = 0; k < 6; k++)
      for (int px = x0 - 1; px <= x0 + TW; px++)
        step_px(0, 0, 0, 0, 0, px, y0 + dys[k]);
    frames(17);
    for (int px = 0; px < 4; px++) step_px(0, 0, 0, 0, 0, px, y0 + 5);
    ticks(30);
    frames(20);

    // Overlap of channels 1 and 2 at the spawn edge.
    step(0, 1, 0, 0, 0);
    spd = 0;
    ticks(10);
    spd = 200;
    frames(1);
    spd = 0;
    ticks(19);
    n = 0;
    d = pick_y(m_lfsr, 2) - m_y[1];
    while ((d >= TH || d <= -TH) && n < 4000) begin
      step(0, 0, 0, 0, 0); n++;
      d = pick_y(m_lfsr, 2) - m_y[1];
    end
    check_eq("search_overlap", 64'(n < 4000), 64'(1));
    step(0, 0, 0, 1, 0);
    yy = (m_y[1] > m_y[2]) ? m_y[1] : m_y[2];
    step_px(0, 0, 0, 0, 0, 645, yy + 1);
    step_px(0, 0, 0, 0, 0, 640, yy);
    step_px(0, 0, 0, 0, 0, 660, yy + 2);

    // endLevel beats startOfLevel; then reset mid-flight.
    step(0, 1, 1, 0, 0);
    step_px(0, 0, 0, 0, 0, 645, yy + 1);
    step_px(0, 0, 0, 0, 0, 450, m_y[0] + 3);
    step(0, 1, 0, 0, 0);
    ticks(10);
    step_px(0, 0, 0, 0, 0, 645, m_y[0] + 3);
    step(0, 0, 0, 0, 1);
    step_px(0, 0, 0, 0, 0, 645, m_y[0] + 3);
    step(0, 1, 0, 0, 0);
    ticks(20);
    repeat (20) step(0, 0, 0, 0, 0);

    // Random traffic.
    step(0, 1, 0, 0, 0);
    for (int c = 0; c < 15000; c++) begin
      if ($urandom_range(0, 99) == 0) spd = $urandom_range(0, 255);
      else if ($urandom_range(0, 49) == 0) spd = $urandom_range(0, 12);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2499) == 0,
           $urandom_range(0, 3999) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5999) == 0);
    end
    step(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
